// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller, the pipeline registers and the bench.
package pipe_hazard_ctrl_pkg;

  localparam logic [0:0]  ST_RUN      = 1'b0;
  localparam logic [0:0]  ST_MEM_WAIT = 1'b1;

  localparam logic [31:0] NOP_INST    = 32'h0000_0000;
  localparam logic [7:0]  NOP_CTRL    = 8'h00;

  typedef struct packed {
    logic dmem_req;
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_flush;
  } hz_ctrl_t;

  // $0 is hardwired, so a load targeting it never creates a real dependency.
  function automatic logic lu_hazard(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       rd1,
    input logic       rd2,
    input logic       ex_memread,
    input logic       ex_regwrite,
    input logic [4:0] ex_wraddr
  );
    return ex_memread && ex_regwrite && (ex_wraddr != 5'd0) &&
           ((rd1 && (rs == ex_wraddr)) || (rd2 && (rt == ex_wraddr)));
  endfunction

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating event counter with synchronous clear.
module hazard_sat_cnt
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush control for the 5-stage core: load-use bubbles, EX redirects and the
// data-memory handshake freeze, plus sticky timeout flag and debug event counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_regread1,
  input  logic             ID_regread2,
  input  logic             EX_memread,
  input  logic             EX_regwrite,
  input  logic [4:0]       EX_wraddr,
  input  logic             EX_redirect,
  input  logic             MEM_memread,
  input  logic             MEM_memwrite,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_stall,
  output logic             IF_ID_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_stall,
  output logic             ID_EX_flush,
  output logic             EX_MEM_stall,
  output logic             MEM_WB_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] rd_cnt
);

  localparam int              TMO_W   = $clog2(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT - 1);

  logic [0:0]       state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             mem_err_q, mem_err_d;
  logic             memacc, memwait, lu_haz, lu_inc, rd_inc;
  hz_ctrl_t         ctl;

  always_comb begin
    memacc  = MEM_memread | MEM_memwrite;
    memwait = memacc & ~dmem_ack;
    lu_haz  = lu_hazard(ID_rs, ID_rt, ID_regread1, ID_regread2,
                        EX_memread, EX_regwrite, EX_wraddr);

    ctl = '0;
    if (rst) begin
      ctl.if_id_flush  = 1'b1;
      ctl.id_ex_flush  = 1'b1;
      ctl.mem_wb_flush = 1'b1;
    end else begin
      ctl.dmem_req = memacc;
      // A frozen EX re-presents redirect/hazard next cycle, so they are simply ignored here.
      if (memwait) begin
        ctl.pc_stall     = 1'b1;
        ctl.if_id_stall  = 1'b1;
        ctl.id_ex_stall  = 1'b1;
        ctl.ex_mem_stall = 1'b1;
        ctl.mem_wb_flush = 1'b1;
      end else if (EX_redirect) begin
        ctl.if_id_flush  = 1'b1;
        ctl.id_ex_flush  = 1'b1;
      end else if (lu_haz) begin
        ctl.pc_stall     = 1'b1;
        ctl.if_id_stall  = 1'b1;
        ctl.id_ex_flush  = 1'b1;
      end
    end

    rd_inc = ~rst & ~memwait & EX_redirect;
    lu_inc = ~rst & ~memwait & ~EX_redirect & lu_haz;

    state_d   = memwait ? ST_MEM_WAIT : ST_RUN;
    tmo_d     = tmo_q;
    mem_err_d = mem_err_q;
    if (state_q == ST_RUN) begin
      tmo_d = '0;
    end else if (memwait) begin
      // Counter parks at its limit; the FSM keeps waiting with the error flagged.
      if (tmo_q == TMO_MAX) mem_err_d = 1'b1;
      else                  tmo_d     = tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      tmo_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      mem_err_q <= mem_err_d;
    end
  end

  hazard_sat_cnt #(.CNT_W(CNT_W)) u_lu_cnt (
    .clk (clk),
    .rst (rst),
    .inc (lu_inc),
    .cnt (lu_cnt)
  );

  hazard_sat_cnt #(.CNT_W(CNT_W)) u_rd_cnt (
    .clk (clk),
    .rst (rst),
    .inc (rd_inc),
    .cnt (rd_cnt)
  );

  assign dmem_req     = ctl.dmem_req;
  assign pc_stall     = ctl.pc_stall;
  assign IF_ID_stall  = ctl.if_id_stall;
  assign IF_ID_flush  = ctl.if_id_flush;
  assign ID_EX_stall  = ctl.id_ex_stall;
  assign ID_EX_flush  = ctl.id_ex_flush;
  assign EX_MEM_stall = ctl.ex_mem_stall;
  assign MEM_WB_flush = ctl.mem_wb_flush;
  assign mem_err      = mem_err_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit that drives the stall/flush inputs of every pipeline register (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC write enable in the 5-stage MIPS core. It detects load-use hazards from ID/EX fields and applies EX-stage control-flow redirects. It also runs the data-memory request/ack handshake, freezing the pipeline while a MEM-stage access is outstanding. Small sticky status and event counters support debug.

## Interface
Parameters:
- CNT_W, 16, width of the saturating event counters
- MEM_TIMEOUT, 64, cycles in MEM_WAIT before mem_err is set; ≥2

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ID_rs  in  5  rs field of the instruction in ID
- ID_rt  in  5  rt field of the instruction in ID
- ID_regread1  in  1  ID instruction reads rs
- ID_regread2  in  1  ID instruction reads rt
- EX_memread  in  1  EX instruction is a load
- EX_regwrite  in  1  EX instruction writes a register
- EX_wraddr  in  5  EX destination register
- EX_redirect  in  1  taken branch, jump or jr resolved in EX this cycle
- MEM_memread  in  1  MEM instruction is a load
- MEM_memwrite  in  1  MEM instruction is a store
- dmem_ack  in  1  data memory completes the access this cycle
- dmem_req  out  1  data memory access request
- pc_stall  out  1  hold PC
- IF_ID_stall, IF_ID_flush  out  1 each
- ID_EX_stall, ID_EX_flush  out  1 each
- EX_MEM_stall  out  1
- MEM_WB_flush  out  1  inject a bubble into WB
- mem_err  out  1  sticky: MEM_TIMEOUT exceeded
- lu_cnt  out  CNT_W  load-use bubbles inserted, saturating
- rd_cnt  out  CNT_W  redirects applied, saturating

## Operation
- States: RUN, MEM_WAIT. Reset enters RUN.
- memacc = MEM_memread | MEM_memwrite.
- dmem_req = memacc, in both states. Held high until dmem_ack.
- lu_haz = EX_memread & EX_regwrite & (EX_wraddr≠0) & ((ID_regread1 & ID_rs==EX_wraddr) | (ID_regread2 & ID_rt==EX_wraddr)).
- memwait = memacc & !dmem_ack.
- Priority, highest first:
  - memwait: pc_stall, IF_ID_stall, ID_EX_stall and EX_MEM_stall = 1; MEM_WB_flush = 1; all other flushes = 0. EX_redirect and lu_haz are ignored. EX is frozen, so they re-present next cycle.
  - EX_redirect: IF_ID_flush = 1 and ID_EX_flush = 1; no stalls; lu_haz ignored. rd_cnt += 1.
  - lu_haz: pc_stall = 1, IF_ID_stall = 1, ID_EX_flush = 1 (NOP bubble). lu_cnt += 1.
  - Otherwise all stall/flush outputs = 0.
- Transitions:
  - RUN→MEM_WAIT when memwait.
  - MEM_WAIT→RUN on the cycle dmem_ack=1. Stalls drop in that same cycle and the pipeline advances at that edge.
  - A zero-wait access (ack in the request cycle) never leaves RUN.
- Timeout counter:
  - Clears on entering MEM_WAIT and increments each MEM_WAIT cycle.
  - When it reaches MEM_TIMEOUT−1 with no ack, mem_err sets. mem_err stays set until rst; the FSM keeps waiting.
- Counters saturate at 2^CNT_W−1. They do not wrap.

## Timing
- Stall/flush/req outputs are combinational from the inputs and state, with zero latency. State, counters and mem_err update on posedge clk.
- While rst=1, all outputs are forced: every flush = 1, every stall = 0, dmem_req = 0.
- Reset values (registered): state RUN, timeout counter 0, mem_err 0, lu_cnt 0, rd_cnt 0.
- rst asserted mid-MEM_WAIT: the outstanding request is dropped and the block is in RUN the next cycle.
- Simultaneous events:
  - EX_redirect with lu_haz: the flush wins and no bubble is counted.
  - memwait with either of them: the freeze wins and neither counter increments.
- Load-use costs exactly 1 bubble. A redirect costs 2 flushed slots.

## Structure
- State encoding (RUN=0, MEM_WAIT=1) lives in the shared header alongside NOP_INST/NOP_CTRL, so the pipeline registers and the bench use one definition.
- One sub-module, hazard_sat_cnt (CNT_W wide, synchronous clear, saturating increment), is instantiated twice, for lu_cnt and rd_cnt.

## Test plan
- Load-use: lw $2 in EX (EX_wraddr=2, EX_memread=1), ID_rs=2, ID_regread1=1 → pc_stall=IF_ID_stall=ID_EX_flush=1 for 1 cycle; lu_cnt 0→1.
- EX_wraddr=0 with a matching ID_rs=0 → no stall; lu_cnt unchanged.
- Redirect together with lu_haz → IF_ID_flush=ID_EX_flush=1, pc_stall=0; rd_cnt=1, lu_cnt=0.
- MEM_memread=1, dmem_ack delayed 3 cycles → dmem_req high 4 cycles; all stalls and MEM_WB_flush high 3 cycles; state returns to RUN on the ack cycle. Zero-wait ack → no stall at all.
- MEM_TIMEOUT=4, ack withheld → mem_err=1 after the 4th MEM_WAIT cycle. A later ack returns to RUN, and mem_err stays 1 until rst.
- rst pulsed during MEM_WAIT → next cycle state RUN, counters 0, dmem_req follows memacc. CNT_W=2 with 5 redirects → rd_cnt=3.
